// File: rtl/prng_roll_ctrl.sv
// Electronic die roller: debounced-free button edge starts a timed xorshift32 roll,
// whose final state's low nibble (mod 10) is shown as a BCD digit.
module prng_roll_ctrl #(
  parameter int unsigned TICK_DIV   = 100,
  parameter int unsigned ROLL_STEPS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] seed,
  input  logic       roll_btn,
  output logic [3:0] digit,
  output logic       busy,
  output logic       valid
);

  typedef enum logic [1:0] {StIdle, StRoll, StShow} state_e;

  state_e      state_q;
  logic        s1_q, s2_q, s3_q;
  logic        rise;
  logic        step;
  logic [9:0]  tick_cnt_q;
  logic [7:0]  step_cnt_q;
  logic [31:0] prng_q;
  logic [31:0] prng_next;
  logic [3:0]  digit_next;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  assign rise = s2_q & ~s3_q;
  assign step = (tick_cnt_q == 10'(TICK_DIV - 1));

  always_comb begin
    prng_next  = xorshift32(prng_q);
    digit_next = prng_next[3:0];
    if (prng_next[3:0] >= 4'd10) begin
      digit_next = prng_next[3:0] - 4'd10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      tick_cnt_q <= '0;
      step_cnt_q <= '0;
      digit      <= '0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      // All-zero is a fixed point of xorshift, so substitute 1.
      prng_q     <= (seed == 6'd0) ? 32'd1 : {26'b0, seed};
    end else begin
      s1_q <= roll_btn;
      s2_q <= s1_q;
      s3_q <= s2_q;
      case (state_q)
        StIdle, StShow: begin
          if (rise) begin
            state_q    <= StRoll;
            tick_cnt_q <= '0;
            step_cnt_q <= '0;
            busy       <= 1'b1;
            valid      <= 1'b0;
          end
        end
        StRoll: begin
          if (step) begin
            tick_cnt_q <= '0;
            step_cnt_q <= step_cnt_q + 8'd1;
            prng_q     <= prng_next;
            digit      <= digit_next;
            if (step_cnt_q == 8'(ROLL_STEPS - 1)) begin
              state_q <= StShow;
              busy    <= 1'b0;
              valid   <= 1'b1;
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + 10'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
